// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: register-file sizes, tag typedefs and the
// capacity of the physical-register free list.
package rename_pkg;

    localparam int NUM_PHYS   = 32;
    localparam int NUM_ARCH   = 16;
    localparam int FREE_DEPTH = NUM_PHYS - NUM_ARCH;

    typedef logic [$clog2(NUM_PHYS)-1:0] PHYS_REG;
    typedef logic [$clog2(NUM_ARCH)-1:0] ARCH_REG;

endpackage

// File: rtl/free_list_ptr.sv
// Wrapping pointer for the free list. Wraps by comparing against DEPTH-1 so
// the capacity does not have to be a power of two.
module free_list_ptr
    import rename_pkg::*;
#(
    parameter int DEPTH = FREE_DEPTH,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    // Advance on inc, returning to zero after the last entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (inc) begin
            if (ptr == PTR_W'(DEPTH - 1)) ptr <= '0;
            else                          ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags feeding the renamer.
// Head supplies the next tag to allocate; commit pushes released tags at tail.
// Optional feature: define FREELIST_DOUBLE_FREE_CHECK_EN to track which tags
// are held in the list and reject (and flag) a release of a tag already held.
module phys_free_list #(
    parameter int NUM_PHYS = rename_pkg::NUM_PHYS,
    parameter int NUM_ARCH = rename_pkg::NUM_ARCH,
    parameter int DEPTH    = NUM_PHYS - NUM_ARCH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alloc_req,
    output logic                         alloc_valid,
    output logic [$clog2(NUM_PHYS)-1:0]  alloc_tag,
    input  logic                         free_valid,
    input  logic [$clog2(NUM_PHYS)-1:0]  free_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         double_free_err
);

    localparam int TAG_W = $clog2(NUM_PHYS);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TAG_W-1:0] entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic pop;
    logic push;
    logic tag_ok;
    logic full;
    logic dbl;
    logic overflow;

    // A pop can only happen while something is held; a request on empty is ignored
    assign alloc_valid = (count != '0);
    assign alloc_tag   = entries[head];
    assign pop         = alloc_req && alloc_valid;

    assign tag_ok   = ({1'b0, free_tag} < (TAG_W + 1)'(NUM_PHYS));
    assign full     = (count == CNT_W'(DEPTH));
    // Full is only a problem when no pop frees a slot in the same cycle
    assign overflow = free_valid && tag_ok && !dbl && full && !pop;
    assign push     = free_valid && tag_ok && !dbl && !overflow;

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    logic [NUM_PHYS-1:0] in_list;
    logic                dbl_err_q;

    // A tag popped this cycle is no longer held, so freeing it again is legal
    assign dbl = free_valid && tag_ok && in_list[free_tag]
                 && !(pop && (alloc_tag == free_tag));

    // Membership vector: clear on pop first, then set on push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                in_list[i] <= (i >= NUM_ARCH);
            end
        end else begin
            if (pop && push && (alloc_tag == free_tag)) begin
                in_list[free_tag] <= 1'b1;
            end else begin
                if (pop)  in_list[alloc_tag] <= 1'b0;
                if (push) in_list[free_tag]  <= 1'b1;
            end
        end
    end

    // One-cycle registered pulse following a rejected double free
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) dbl_err_q <= 1'b0;
        else        dbl_err_q <= dbl;
    end

    assign double_free_err = dbl_err_q;
`else
    assign dbl             = 1'b0;
    assign double_free_err = 1'b0;
`endif

    free_list_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head (
        .clk   (clk),
        .reset (reset),
        .inc   (pop),
        .ptr   (head)
    );

    free_list_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail (
        .clk   (clk),
        .reset (reset),
        .inc   (push),
        .ptr   (tail)
    );

    // Storage: reset holds every unmapped tag in ascending order; pushes write at tail
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= TAG_W'(NUM_ARCH + i);
            end
        end else if (push) begin
            entries[tail] <= free_tag;
        end
    end

    // Occupancy: unchanged when a pop and a push land together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= CNT_W'(DEPTH);
        end else if (pop && !push) begin
            count <= count - CNT_W'(1);
        end else if (push && !pop) begin
            count <= count + CNT_W'(1);
        end
    end

    // Flag pushes that are dropped because they can never be legal
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(free_valid && !tag_ok))
                else $error("phys_free_list: free_tag %0d out of range", free_tag);
            assert (!overflow)
                else $error("phys_free_list: push into full list dropped");
        end
    end

endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: directed scenarios plus a randomized
// run compared against a queue-based model of the free list.
module tb_phys_free_list;

    logic       clk;
    logic       reset;
    logic       alloc_req;
    logic       alloc_valid;
    logic [4:0] alloc_tag;
    logic       free_valid;
    logic [4:0] free_tag;
    logic [4:0] count;
    logic       double_free_err;

    int checks;
    int errors;

    phys_free_list dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_req       (alloc_req),
        .alloc_valid     (alloc_valid),
        .alloc_tag       (alloc_tag),
        .free_valid      (free_valid),
        .free_tag        (free_tag),
        .count           (count),
        .double_free_err (double_free_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every task starts and ends 1 time unit after a rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_tag   = '0;
        reset      = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL reset_count got %0d want 16", count); end
        checks++; if (alloc_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got %0b want 1", alloc_valid); end
        checks++; if (alloc_tag !== 5'd16) begin errors++; $display("FAIL reset_tag got %0d want 16", alloc_tag); end
        checks++; if (double_free_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", double_free_err); end
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc_req = 1'b1;
            #1;
            checks++; if (alloc_tag !== 5'(16 + i)) begin errors++; $display("FAIL drain_tag[%0d] got %0d want %0d", i, alloc_tag, 16 + i); end
            cycle();
        end
        alloc_req = 1'b0;
        checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b want 0", alloc_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL drain_count got %0d want 0", count); end
    endtask

    task automatic test_empty_free();
        // Continues from the drained list
        alloc_req  = 1'b1;
        free_valid = 1'b1;
        free_tag   = 5'd5;
        #1;
        checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL empty_bypass got %0b want 0", alloc_valid); end
        cycle();
        free_valid = 1'b0;
        alloc_req  = 1'b0;
        checks++; if (alloc_valid !== 1'b1) begin errors++; $display("FAIL empty_valid got %0b want 1", alloc_valid); end
        checks++; if (alloc_tag !== 5'd5) begin errors++; $display("FAIL empty_tag got %0d want 5", alloc_tag); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL empty_count got %0d want 1", count); end
    endtask

    task automatic test_full_swap();
        do_reset();
        alloc_req  = 1'b1;
        free_valid = 1'b1;
        free_tag   = 5'd3;
        #1;
        checks++; if (alloc_tag !== 5'd16) begin errors++; $display("FAIL swap_pop got %0d want 16", alloc_tag); end
        cycle();
        free_valid = 1'b0;
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL swap_count got %0d want 16", count); end
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (alloc_tag !== ((i < 15) ? 5'(17 + i) : 5'd3)) begin
                errors++; $display("FAIL swap_order[%0d] got %0d want %0d", i, alloc_tag, (i < 15) ? 17 + i : 3);
            end
            cycle();
        end
        alloc_req = 1'b0;
    endtask

    task automatic test_wrap();
        logic [4:0] exp_tags [16];
        do_reset();
        alloc_req = 1'b1;
        cycle();
        cycle();
        alloc_req  = 1'b0;
        free_valid = 1'b1;
        free_tag   = 5'd17;
        cycle();
        free_tag   = 5'd16;
        cycle();
        free_valid = 1'b0;
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL wrap_count got %0d want 16", count); end
        for (int i = 0; i < 14; i++) exp_tags[i] = 5'(18 + i);
        exp_tags[14] = 5'd17;
        exp_tags[15] = 5'd16;
        alloc_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++; if (alloc_tag !== exp_tags[i]) begin errors++; $display("FAIL wrap_order[%0d] got %0d want %0d", i, alloc_tag, exp_tags[i]); end
            cycle();
        end
        alloc_req = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL wrap_empty got %0d want 0", count); end
    endtask

    task automatic test_double_free();
        do_reset();
        alloc_req = 1'b1;
        cycle();
        cycle();
        alloc_req  = 1'b0;
        free_valid = 1'b1;
        free_tag   = 5'd20;
        cycle();
        free_valid = 1'b0;
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
        checks++; if (double_free_err !== 1'b1) begin errors++; $display("FAIL dbl_err got %0b want 1", double_free_err); end
        checks++; if (count !== 5'd14) begin errors++; $display("FAIL dbl_count got %0d want 14", count); end
        cycle();
        checks++; if (double_free_err !== 1'b0) begin errors++; $display("FAIL dbl_err_pulse got %0b want 0", double_free_err); end
`else
        checks++; if (double_free_err !== 1'b0) begin errors++; $display("FAIL dbl_err got %0b want 0", double_free_err); end
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL dbl_count got %0d want 15", count); end
`endif
    endtask

    task automatic test_mid_reset();
        do_reset();
        alloc_req = 1'b1;
        repeat (5) cycle();
        alloc_req  = 1'b0;
        free_valid = 1'b1;
        free_tag   = 5'd2;
        cycle();
        free_tag   = 5'd9;
        cycle();
        free_valid = 1'b0;
        checks++; if (count !== 5'd13) begin errors++; $display("FAIL mid_pre_count got %0d want 13", count); end
        // Asynchronous assertion away from any clock edge
        #2;
        reset = 1'b0;
        #1;
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL mid_async_count got %0d want 16", count); end
        cycle();
        reset = 1'b1;
        cycle();
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL mid_count got %0d want 16", count); end
        checks++; if (alloc_tag !== 5'd16) begin errors++; $display("FAIL mid_tag got %0d want 16", alloc_tag); end
        checks++; if (double_free_err !== 1'b0) begin errors++; $display("FAIL mid_err got %0b want 0", double_free_err); end
    endtask

    // Random pops/frees; model is a FIFO of free tags plus a pool of tags in use
    task automatic test_random();
        int q[$];
        int outp[$];
        int idx;
        int ftag;
        logic req;
        logic fv;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            q.push_back(16 + i);
            outp.push_back(i);
        end
        for (int n = 0; n < 400; n++) begin
            req = 1'($urandom_range(0, 1));
            fv  = (outp.size() > 0) && ($urandom_range(0, 2) != 0)
                  && ((q.size() < 16) || (req && q.size() > 0));
            ftag = 0;
            if (fv) begin
                idx  = $urandom_range(0, outp.size() - 1);
                ftag = outp[idx];
                outp.delete(idx);
            end
            alloc_req  = req;
            free_valid = fv;
            free_tag   = 5'(ftag);
            #1;
            checks++; if (alloc_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %0b want %0b", n, alloc_valid, q.size() != 0); end
            checks++; if (count !== 5'(q.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, count, q.size()); end
            if (q.size() != 0) begin
                checks++; if (alloc_tag !== 5'(q[0])) begin errors++; $display("FAIL rnd_tag[%0d] got %0d want %0d", n, alloc_tag, q[0]); end
            end
            checks++; if (double_free_err !== 1'b0) begin errors++; $display("FAIL rnd_err[%0d] got %0b want 0", n, double_free_err); end
            cycle();
            if (req && q.size() > 0) outp.push_back(q.pop_front());
            if (fv) q.push_back(ftag);
        end
        alloc_req  = 1'b0;
        free_valid = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_tag   = '0;
        #2;
        test_reset();
        test_drain();
        test_empty_free();
        test_full_swap();
        test_wrap();
        test_double_free();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
